// File: rtl/ifu32.sv
// ifu32: instruction fetch unit issuing single-outstanding word reads and handing instructions to decode.
// Define IFU32_MISALIGN_EN to flag misaligned redirect targets via fetch_fault and halt fetch.
//
// state  | meaning
// S_REQ  | request pending on imem at pc
// S_WAIT | request accepted, waiting for read data
// S_HOLD | instruction presented to decode
// S_DROP | squashed request outstanding, drain and discard its response
module ifu32 #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_fault
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nx;
    logic [WIDTH-1:0] target;
    logic             req_hs;
    logic             halt_nx;

    assign req_hs        = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc;

`ifdef IFU32_MISALIGN_EN
    logic fault;

    assign target      = redirect_pc;
    // every redirect re-evaluates the fault; only a redirect or reset can clear it
    assign halt_nx     = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault;
    assign fetch_fault = fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= halt_nx;
        end
    end
`else
    assign target      = redirect_pc & ~WIDTH'(3);
    assign halt_nx     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            S_REQ:  if (req_hs) state_nx = S_WAIT;
            S_WAIT: if (imem_rsp_valid) begin
                        state_nx = S_HOLD;
                        pc_nx    = pc + WIDTH'(4);
                    end
            S_HOLD: if (inst_ready) state_nx = S_REQ;
            S_DROP: if (imem_rsp_valid) state_nx = S_REQ;
            default: state_nx = S_REQ;
        endcase
        // redirect wins; any request already accepted becomes stale and must be drained
        if (redirect_valid) begin
            pc_nx = target;
            case (state)
                S_REQ:   state_nx = req_hs ? S_DROP : S_REQ;
                S_WAIT:  state_nx = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_nx = S_REQ;
                S_DROP:  state_nx = imem_rsp_valid ? S_REQ : S_DROP;
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            imem_req_valid <= (state_nx == S_REQ) && !halt_nx;
            inst_valid     <= (state_nx == S_HOLD);
            if (state == S_WAIT && imem_rsp_valid && !redirect_valid) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_ifu32.sv
// Self-checking bench for ifu32: event-level fetch model, directed scenarios, then randomized traffic.
module tb_ifu32;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    ifu32 #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: next fetch address, the one outstanding read, the instruction held for decode
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    logic [31:0] m_held_data;
    logic [31:0] m_held_pc;
    bit          m_out;
    bit          m_stale;
    bit          m_held;
    bit          m_fault;
    int          cnt;
    int          mem_delay = 0;

    logic [31:0] acc_log[$];
    logic [31:0] acc_cyc[$];
    logic [31:0] inst_pc_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] acc_at(int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] acc_cyc_at(int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] ipc_at(int i);
        return (i < inst_pc_log.size()) ? inst_pc_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic bit m_rv();
        return !m_out && !m_held && !m_fault;
    endfunction

    // one clock: compare outputs to the model, drive inputs, then advance the model
    task automatic step(input bit rdv, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
        bit          exp_rv;
        bit          acc;
        bit          rsp_v;
        logic [31:0] rdata;
        @(negedge clk);
        cyc++;
        exp_rv = m_rv();
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_held));
        if (m_held) begin
            chk("inst", inst, m_held_data);
            chk("inst_pc", inst_pc, m_held_pc);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));

        rsp_v = 1'b0;
        if (m_out) begin
            if (cnt == 0) rsp_v = 1'b1;
            else cnt--;
        end
        rdata          = $urandom;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rdata;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;

        acc = exp_rv && rq_rdy;
        if (m_held && in_rdy && !rdv) begin
            m_held = 1'b0;
            inst_pc_log.push_back(m_held_pc);
        end
        if (rsp_v) begin
            m_out = 1'b0;
            if (!m_stale && !rdv) begin
                m_held      = 1'b1;
                m_held_data = rdata;
                m_held_pc   = m_out_addr;
                m_pc        = m_out_addr + 32'd4;
            end
        end
        if (acc) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_out_addr = m_pc;
            cnt        = (mem_delay < 0) ? int'($urandom_range(3, 0)) : mem_delay;
            acc_log.push_back(m_pc);
            acc_cyc.push_back(32'(cyc));
        end
        if (rdv) begin
            m_held = 1'b0;
            if (m_out) m_stale = 1'b1;
`ifdef IFU32_MISALIGN_EN
            m_pc    = rpc;
            m_fault = (rpc[1:0] != 2'b00);
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr", imem_req_addr, RESET_PC);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;   // stray response while in S_REQ must be ignored
        imem_rsp_data  = $urandom;
        m_pc    = RESET_PC;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_held  = 1'b0;
        m_fault = 1'b0;
        cnt     = 0;
    endtask

    task automatic wait_acc(output logic [31:0] a);
        int n = acc_log.size();
        int k = 0;
        while (acc_log.size() == n && k < 40) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            k++;
        end
        a = acc_at(n);
    endtask

    task automatic wait_inst(output logic [31:0] p);
        int n = inst_pc_log.size();
        int k = 0;
        while (inst_pc_log.size() == n && k < 40) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            k++;
        end
        p = ipc_at(n);
    endtask

    task automatic wait_rv();
        int k = 0;
        while (!m_rv() && k < 40) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            k++;
        end
        chk("wait_req_timeout", 32'(m_rv()), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] p;
        int          n;
        int          k;
        bit          rdv;
        logic [31:0] rpc;

        do_reset();

        // streaming with zero-wait memory and ready decode
        repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("seq_addr0", acc_at(0), 32'h8000_0000);
        chk("seq_addr1", acc_at(1), 32'h8000_0004);
        chk("seq_addr2", acc_at(2), 32'h8000_0008);
        chk("seq_spacing", acc_cyc_at(1) - acc_cyc_at(0), 32'd3);
        chk("seq_ipc0", ipc_at(0), 32'h8000_0000);
        chk("seq_ipc1", ipc_at(1), 32'h8000_0004);

        // decode stalls five cycles with an instruction held
        k = 0;
        while (!m_held && k < 20) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            k++;
        end
        repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0);
        n = inst_pc_log.size();
        wait_acc(a);
        chk("stall_next_addr", a, 32'h8000_0010);
        chk("stall_ipc", ipc_at(n), 32'h8000_000C);

        // redirect while waiting, response three cycles later
        mem_delay = 3;
        k = 0;
        while (!(m_out && !m_stale) && k < 20) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            k++;
        end
        mem_delay = 0;
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        wait_acc(a);
        chk("wait_redir_addr", a, 32'h0000_0100);
        wait_inst(p);
        chk("wait_redir_ipc", p, 32'h0000_0100);

        // redirect on the request handshake
        wait_rv();
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        wait_acc(a);
        chk("hs_redir_addr", a, 32'h0000_0200);
        wait_inst(p);
        chk("hs_redir_ipc", p, 32'h0000_0200);

        // redirect on the response beat
        k = 0;
        while (!(m_out && !m_stale && cnt == 0) && k < 20) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            k++;
        end
        step(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        wait_acc(a);
        chk("rsp_redir_addr", a, 32'h0000_0300);
        wait_inst(p);
        chk("rsp_redir_ipc", p, 32'h0000_0300);

        // pc wrap
        wait_rv();
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        wait_acc(a);
        chk("wrap_addr0", a, 32'hFFFF_FFFC);
        wait_acc(a);
        chk("wrap_addr1", a, 32'h0000_0000);

        // misaligned redirect
        wait_rv();
        step(1'b1, 32'h0000_0102, 1'b0, 1'b1);
`ifdef IFU32_MISALIGN_EN
        n = acc_log.size();
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("misalign_fault", 32'(fetch_fault), 32'd1);
        chk("misalign_no_req", 32'(acc_log.size()), 32'(n));
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        wait_acc(a);
        chk("realign_addr", a, 32'h0000_0200);
        chk("realign_fault", 32'(fetch_fault), 32'd0);
`else
        wait_acc(a);
        chk("mask_addr", a, 32'h0000_0100);
`endif

        // randomized traffic with a reset in the middle
        mem_delay = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            rdv = ($urandom_range(19, 0) == 0);
            rpc = $urandom;
            if ($urandom_range(3, 0) != 0) rpc[1:0] = 2'b00;
            step(rdv, rpc, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
        end
        chk("random_progress", 32'(inst_pc_log.size() > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
